mmio_port_responder: RTL and testbench
======================================

# mmio_port_responder

Memory-mapped I/O responder on the processor's data-memory bus, the slave side of the core's load/store initiator. It decodes a 16-byte window and serves `lw`/`sw` accesses with single-cycle semantics. Writes to the data register are queued in a small FIFO and paced out onto `PortOut` with a strobe. `PortIn` is synchronized and exposed for reads, with a sticky change flag. The top level muxes `ReadData` against the RAM using `Hit`.

## Interface
- `BASE_ADDR`, default 32'h1001_0040: window base; bits [3:0] must be 0.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of 2, at least 2.
- `HOLD_CYCLES`, default 8: minimum cycles between successive `PortOut` updates; must be at least 2.
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `Address`  in  32  byte address from the core ALU result.
- `WriteData`  in  32  store data (rt).
- `MemWrite`  in  1  store request.
- `MemRead`  in  1  load request.
- `ReadData`  out  32  load data; combinational.
- `Hit`  out  1  combinational; `Address[31:4]==BASE_ADDR[31:4]`.
- `PortIn`  in  8  asynchronous external input.
- `PortOut`  out  32  registered output port.
- `PortStrobe`  out  1  one-cycle pulse, registered, when `PortOut` updates.

## Operation
- `Address[3:2]` selects the register. `Address[1:0]` is ignored.
- **+0x0 TXDATA**
  - Write: when `Hit & MemWrite` and the FIFO is not full, push `WriteData`.
  - Write while full: the data is dropped and `ovf` is set.
  - Read: returns the current `PortOut`.
- **+0x4 PORTIN**
  - Read: returns `{24'b0, in_sync}`.
  - Write: ignored.
- **+0x8 STATUS**
  - Read: returns `{27'b0, in_chg, ovf, busy, full, empty}`.
  - Write: bit3=1 clears `ovf`; bit4=1 clears `in_chg`. All other bits are ignored.
- **+0xC COUNT**
  - Read: returns the FIFO occupancy, zero-extended.
  - Write: ignored.
- `ReadData` = selected register when `Hit & MemRead`, else 32'b0.
- Input path: 2-flop synchronizer `PortIn` -> `s1` -> `in_sync`. A third register `in_prev` holds the previous `in_sync`. `in_chg` sets on the edge following a cycle where `in_sync != in_prev`.
- Drain FSM has two states, IDLE and HOLD. `busy` = (state==HOLD).
  - IDLE with FIFO non-empty: on the next edge, `PortOut` <= head, pop, `PortStrobe` <= 1, `hold_cnt` <= HOLD_CYCLES-1, state -> HOLD.
  - HOLD with `hold_cnt` != 0: decrement `hold_cnt`; `PortStrobe` <= 0.
  - HOLD with `hold_cnt` == 0 and FIFO non-empty: perform the load actions above and stay in HOLD.
  - HOLD with `hold_cnt` == 0 and FIFO empty: state -> IDLE.
- FIFO: read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Occupancy is tracked in a separate counter of log2(FIFO_DEPTH)+1 bits.
- Boundary rules:
  - Push and pop on the same edge: both occur and occupancy is unchanged.
  - `full` and `empty` are evaluated before the edge. A push while full is refused even if a pop occurs on the same edge.
  - Sticky set and software clear on the same edge: set wins.
  - `MemRead` and `MemWrite` both high: the write takes effect and `ReadData` shows the pre-edge value.
- Reset (`reset`==0 at an edge, including mid-drain):
  - FIFO emptied and pointers cleared; state IDLE; `hold_cnt` = 0.
  - `PortOut` = 0; `PortStrobe` = 0; `ovf` = 0 and `in_chg` = 0.
  - `s1`, `in_sync` and `in_prev` = 0.

## Timing
- Reads are combinational in the same cycle as the access, consistent with the single-cycle core.
- Writes take effect at the rising edge of the cycle in which `Hit & MemWrite` is asserted.
- Push at edge N into an empty FIFO with the FSM in IDLE: `PortOut` and `PortStrobe` update at edge N+1.
- Back-to-back drain: successive strobes are exactly `HOLD_CYCLES` edges apart.
- `PortIn` change to `PORTIN` readback: 2 edges. To `in_chg`=1: 3 edges.
- `Hit` and `ReadData` have no dependence on `clk`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, release. Required: `PortOut`=0, `PortStrobe`=0, and a STATUS read returns 32'h0000_0001 (empty only).
- Single store: `sw` 32'hCAFE_0001 to 0x1001_0040 at edge N. Required: `PortOut`=32'hCAFE_0001 and `PortStrobe`=1 at edge N+1; `PortStrobe`=0 at N+2; COUNT reads 0.
- Burst with overflow, default parameters: store 1, 2, 3, 4, 5, 6 on consecutive cycles.
  - Value 1 is popped one edge after its push, freeing a slot, so values 1–5 are accepted. Value 6 arrives with the FIFO full and is dropped; `ovf` sets and STATUS bit3 reads 1.
  - `PortOut` shows 1, 2, 3, 4, 5 at 8-edge spacing; value 6 never appears.
  - Writing 32'h8 to STATUS then clears `ovf`.
- Input change: drive `PortIn` 8'h00 -> 8'hA5. Required: PORTIN reads 32'h0000_00A5 after 2 edges; STATUS bit4=1 after 3 edges; writing 32'h10 to STATUS clears it.
- Same-edge push/pop: with the FIFO full and the FSM popping, store 32'h77. Required: the store is refused, `ovf`=1, and COUNT drops by 1.
- Reset mid-drain: with 3 entries queued and the FSM in HOLD, assert reset for 1 edge. Required: COUNT=0, `PortOut`=0, state IDLE, and no further strobes.

Source files
------------

// File: rtl/mmio_port_responder.sv
// MMIO responder on the data-memory bus: a 16-byte register window with a paced TX FIFO
// that drives PortOut/PortStrobe, and a synchronized PortIn with a sticky change flag.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0040,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        PortStrobe
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_PORTIN = 2'd1,
    REG_STATUS = 2'd2,
    REG_COUNT  = 2'd3
  } reg_sel_e;

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [HW-1:0]  hold_cnt_q;
  logic [31:0]    port_out_q;
  logic           strobe_q;
  logic           ovf_q, in_chg_q;
  logic [7:0]     s1_q, in_sync_q, in_prev_q;

  reg_sel_e       sel;
  logic           full, empty, busy;
  logic           tx_wr, st_wr, push, load;
  logic           ovf_set, in_chg_set;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^Address[1:0];

  assign Hit        = (Address[31:4] == BASE_ADDR[31:4]);
  assign sel        = reg_sel_e'(Address[3:2]);
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign busy       = (state_q == HOLD);
  assign tx_wr      = Hit && MemWrite && (sel == REG_TXDATA);
  assign st_wr      = Hit && MemWrite && (sel == REG_STATUS);
  // full is the pre-edge occupancy, so a same-edge pop never rescues a push
  assign push       = tx_wr && !full;
  assign ovf_set    = tx_wr && full;
  assign in_chg_set = (in_sync_q != in_prev_q);

  assign PortOut    = port_out_q;
  assign PortStrobe = strobe_q;

  // Drain FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Drain FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!empty) state_d = HOLD;
      HOLD: if (hold_cnt_q == '0 && empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drain FSM: outputs
  always_comb begin
    load = 1'b0;
    case (state_q)
      IDLE:    load = !empty;
      HOLD:    load = !empty && (hold_cnt_q == '0);
      default: load = 1'b0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_cnt_q <= '0;
      port_out_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      strobe_q <= load;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        port_out_q <= mem_q[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        hold_cnt_q <= HW'(HOLD_CYCLES - 1);
      end else if (state_q == HOLD && hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
      end
    end
  end

  // Sticky flags: a set on the same edge as a software clear wins
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q     <= 1'b0;
      in_chg_q  <= 1'b0;
      s1_q      <= '0;
      in_sync_q <= '0;
      in_prev_q <= '0;
    end else begin
      ovf_q     <= (ovf_q && !(st_wr && WriteData[3])) || ovf_set;
      in_chg_q  <= (in_chg_q && !(st_wr && WriteData[4])) || in_chg_set;
      s1_q      <= PortIn;
      in_sync_q <= s1_q;
      in_prev_q <= in_sync_q;
    end
  end

  always_comb begin
    ReadData = '0;
    if (Hit && MemRead) begin
      case (sel)
        REG_TXDATA: ReadData = port_out_q;
        REG_PORTIN: ReadData = {24'b0, in_sync_q};
        REG_STATUS: ReadData = {27'b0, in_chg_q, ovf_q, busy, full, empty};
        REG_COUNT:  ReadData = {{(32 - CW){1'b0}}, count_q};
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: a queue-based model checked every cycle, plus directed
// scenarios with hand-computed register values and strobe timing.
module tb_mmio_port_responder;
  localparam logic [31:0] BASE  = 32'h1001_0040;
  localparam int          DEPTH = 4;
  localparam int          HOLD  = 8;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_PIN = BASE + 32'h4;
  localparam logic [31:0] A_ST  = BASE + 32'h8;
  localparam logic [31:0] A_CNT = BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, Hit, PortStrobe;
  logic [7:0]  PortIn;

  int tests = 0;
  int fails = 0;

  mmio_port_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .PortStrobe(PortStrobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we, input logic re);
    Address   = a;
    WriteData = d;
    MemWrite  = we;
    MemRead   = re;
  endtask

  // Model state: FIFO contents as a queue, drain pacing as "edges since last output update"
  logic [31:0] mq[$];
  logic [31:0] m_out;
  logic        m_stb, m_busy, m_ovf, m_chg;
  logic [7:0]  m_s1, m_sync, m_prev;
  int          cyc = 0;
  int          m_last = 0;
  bit          armed = 0;
  logic [31:0] log_v[$];
  int          log_c[$];

  function automatic logic [31:0] m_rdata();
    logic [31:0] r;
    r = '0;
    if (Address[31:4] == BASE[31:4] && MemRead) begin
      case (Address[3:2])
        2'd0: r = m_out;
        2'd1: r = {24'b0, m_sync};
        2'd2: r = {27'b0, m_chg, m_ovf, m_busy, (mq.size() == DEPTH), (mq.size() == 0)};
        default: r = 32'(mq.size());
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bit was_full, was_empty, hit, wr_tx, wr_st, may_load, chg_set;
    cyc++;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (!reset) begin
      mq.delete();
      m_out = '0; m_stb = 0; m_busy = 0; m_ovf = 0; m_chg = 0;
      m_s1 = '0; m_sync = '0; m_prev = '0;
      armed = 1;
    end else begin
      hit      = (Address[31:4] == BASE[31:4]);
      wr_tx    = hit && MemWrite && (Address[3:2] == 2'd0);
      wr_st    = hit && MemWrite && (Address[3:2] == 2'd2);
      may_load = !m_busy || (cyc - m_last >= HOLD);
      chg_set  = (m_sync != m_prev);
      if (may_load && !was_empty) begin
        m_out  = mq.pop_front();
        m_stb  = 1;
        m_busy = 1;
        m_last = cyc;
      end else begin
        m_stb = 0;
        if (m_busy && (cyc - m_last >= HOLD)) m_busy = 0;
      end
      if (wr_tx && !was_full) mq.push_back(WriteData);
      m_ovf  = (m_ovf && !(wr_st && WriteData[3])) || (wr_tx && was_full);
      m_chg  = (m_chg && !(wr_st && WriteData[4])) || chg_set;
      m_prev = m_sync;
      m_sync = m_s1;
      m_s1   = PortIn;
    end
    #1;
    if (armed) begin
      chk("cyc_portout", PortOut, m_out);
      chk("cyc_strobe", {31'b0, PortStrobe}, {31'b0, m_stb});
      chk("cyc_hit", {31'b0, Hit}, {31'b0, (Address[31:4] == BASE[31:4])});
      chk("cyc_rdata", ReadData, m_rdata());
      if (PortStrobe === 1'b1) begin
        log_v.push_back(PortOut);
        log_c.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    reset = 1'b0;
    PortIn = 8'h00;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset state
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_strobe", {31'b0, PortStrobe}, 32'h0);
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    #1 chk("rst_status", ReadData, 32'h0000_0001);
    drive(32'h2000_0000, 32'h0, 1'b0, 1'b1);
    #1 chk("miss_rdata", ReadData, 32'h0);

    // Single store
    @(negedge clk);
    drive(A_TX, 32'hCAFE_0001, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("st_pre_out", PortOut, 32'h0);
    drive(A_CNT, 32'h0, 1'b0, 1'b1);
    #1 chk("st_cnt1", ReadData, 32'h1);
    @(posedge clk); #2;
    chk("st_out", PortOut, 32'hCAFE_0001);
    chk("st_stb", {31'b0, PortStrobe}, 32'h1);
    chk("st_cnt0", ReadData, 32'h0);
    @(posedge clk); #2;
    chk("st_stb_low", {31'b0, PortStrobe}, 32'h0);
    repeat (10) @(posedge clk);
    #2;

    // Burst 1..6 with overflow on 6
    log_v.delete(); log_c.delete();
    t0 = 0;
    for (int i = 1; i <= 6; i++) begin
      drive(A_TX, 32'(i), 1'b1, 1'b0);
      @(posedge clk); #2;
      if (i == 1) t0 = cyc;
    end
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    #1 chk("burst_status", ReadData, 32'h0000_000E);
    repeat (45) @(posedge clk);
    #2;
    chk("burst_nstb", 32'(log_v.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_v.size(); i++) begin
      chk("burst_val", log_v[i], 32'(i + 1));
      if (i == 0) chk("burst_first", 32'(log_c[0] - t0), 32'd1);
      else        chk("burst_gap", 32'(log_c[i] - log_c[i-1]), 32'd8);
    end
    drive(A_ST, 32'h8, 1'b1, 1'b0);
    @(posedge clk); #2;
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    #1 chk("ovf_clr", ReadData, 32'h0000_0001);

    // Input change and in_chg
    PortIn = 8'hA5;
    drive(A_PIN, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("pin_e1", ReadData, 32'h0);
    @(posedge clk); #2;
    chk("pin_e2", ReadData, 32'h0000_00A5);
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    #1 chk("chg_e2", ReadData, 32'h0000_0001);
    @(posedge clk); #2;
    chk("chg_e3", ReadData, 32'h0000_0011);
    drive(A_ST, 32'h10, 1'b1, 1'b0);
    @(posedge clk); #2;
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    #1 chk("chg_clr", ReadData, 32'h0000_0001);

    // Set vs clear on the same edge, with read+write together
    PortIn = 8'h5A;
    @(posedge clk); #2;
    @(posedge clk); #2;
    drive(A_ST, 32'h10, 1'b1, 1'b1);
    #1 chk("rw_pre_edge", ReadData, 32'h0000_0001);
    @(posedge clk); #2;
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    #1 chk("set_wins", ReadData, 32'h0000_0011);
    drive(A_ST, 32'h10, 1'b1, 1'b0);
    @(posedge clk); #2;
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    #1 chk("chg_clr2", ReadData, 32'h0000_0001);

    // Push refused while full even with a pop on the same edge
    for (int i = 0; i < 5; i++) begin
      drive(A_TX, 32'hB0 + 32'(i), 1'b1, 1'b0);
      @(posedge clk); #2;
    end
    drive(A_CNT, 32'h0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    chk("pp_cnt_full", ReadData, 32'h4);
    drive(A_TX, 32'h77, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("pp_stb", {31'b0, PortStrobe}, 32'h1);
    chk("pp_out", PortOut, 32'hB1);
    drive(A_CNT, 32'h0, 1'b0, 1'b1);
    #1 chk("pp_cnt", ReadData, 32'h3);
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    #1 chk("pp_status", ReadData, 32'h0000_000C);

    // Reset mid-drain
    reset = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    chk("mr_portout", PortOut, 32'h0);
    chk("mr_strobe", {31'b0, PortStrobe}, 32'h0);
    drive(A_ST, 32'h0, 1'b0, 1'b1);
    #1 chk("mr_status", ReadData, 32'h0000_0001);
    drive(A_CNT, 32'h0, 1'b0, 1'b1);
    #1 chk("mr_count", ReadData, 32'h0);
    log_v.delete(); log_c.delete();
    repeat (30) @(posedge clk);
    #2;
    chk("mr_nostb", 32'(log_v.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
